// File: rtl/neural_scan_sequencer.sv
// neural_scan_sequencer: masked channel scan with mux settle, ADC handshake, timeout and continuous repeat
module neural_scan_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_ID_WIDTH = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int NUM_CH = 2**CH_ID_WIDTH
) (
  input  logic                   sensor_clk,
  input  logic                   sensor_rst_n,
  input  logic                   scan_start,
  input  logic                   scan_stop,
  input  logic                   continuous,
  input  logic [NUM_CH-1:0]      ch_enable_mask,
  input  logic                   err_clr,
  output logic [CH_ID_WIDTH-1:0] adc_mux_sel,
  output logic                   adc_conv_req,
  input  logic                   adc_conv_done,
  input  logic [DATA_WIDTH-1:0]  adc_conv_data,
  output logic [DATA_WIDTH-1:0]  seq_data,
  output logic [CH_ID_WIDTH-1:0] seq_channel,
  output logic                   seq_valid,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic                   timeout_err
);
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [9:0] tcnt, tcnt_d;
  logic [NUM_CH-1:0] shadow, shadow_d;
  logic stop_pend, stop_d, req_d, valid_d, done_d, err_d, found, tmo, fin, halt;
  logic [CH_ID_WIDTH-1:0] sel_d, chan_d, nxt, low;
  logic [DATA_WIDTH-1:0] data_d;
  always_comb begin
    nxt = '0;
    found = 1'b0;
    low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (shadow[i] && CH_ID_WIDTH'(i) > adc_mux_sel) begin
        nxt = CH_ID_WIDTH'(i);
        found = 1'b1;
      end
      if (ch_enable_mask[i]) low = CH_ID_WIDTH'(i);
    end
  end
  assign scan_busy = state != IDLE;
  assign tmo = state == WAIT && !adc_conv_done && tcnt == 10'(TIMEOUT_CYCLES - 1);
  assign fin = state == WAIT && (adc_conv_done || tmo);
  assign halt = stop_pend || scan_stop;
  assign req_d = state == SETTLE && !scan_stop && cnt == 8'(SETTLE_CYCLES - 1);
  assign valid_d = state == WAIT && adc_conv_done;
  assign data_d = valid_d ? adc_conv_data : seq_data;
  assign chan_d = valid_d ? adc_mux_sel : seq_channel;
  assign done_d = fin && !halt && !found;
  assign err_d = tmo || (timeout_err && !err_clr);
  assign stop_d = state == WAIT && halt && !fin;
  assign cnt_d = state == SETTLE ? cnt + 8'd1 : '0;
  assign tcnt_d = state == WAIT ? tcnt + 10'd1 : '0;
  always_comb begin
    state_d = state;
    shadow_d = shadow;
    sel_d = adc_mux_sel;
    case (state)
      IDLE: if (scan_start && |ch_enable_mask) begin
        state_d = SETTLE;
        shadow_d = ch_enable_mask;
        sel_d = low;
      end
      SETTLE: state_d = scan_stop ? IDLE : req_d ? WAIT : SETTLE;
      WAIT: if (fin) begin
        if (halt) state_d = IDLE;
        else if (found) begin
          state_d = SETTLE;
          sel_d = nxt;
        end else if (continuous && |ch_enable_mask) begin
          state_d = SETTLE;
          shadow_d = ch_enable_mask;
          sel_d = low;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      shadow <= '0;
      stop_pend <= 1'b0;
      adc_mux_sel <= '0;
      adc_conv_req <= 1'b0;
      seq_data <= '0;
      seq_channel <= '0;
      seq_valid <= 1'b0;
      scan_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      tcnt <= tcnt_d;
      shadow <= shadow_d;
      stop_pend <= stop_d;
      adc_mux_sel <= sel_d;
      adc_conv_req <= req_d;
      seq_data <= data_d;
      seq_channel <= chan_d;
      seq_valid <= valid_d;
      scan_done <= done_d;
      timeout_err <= err_d;
    end
  end
endmodule

// File: tb/tb_neural_scan_sequencer.sv
// tb_neural_scan_sequencer: scoreboard and vector-table bench for neural_scan_sequencer
module tb_neural_scan_sequencer;
  localparam int DW = 16, CW = 4, NCH = 16, SET = 4, TMO = 64;
  logic sensor_clk = 1'b0, sensor_rst_n = 1'b0;
  logic scan_start = 1'b0, scan_stop = 1'b0, continuous = 1'b0, err_clr = 1'b0;
  logic [NCH-1:0] ch_enable_mask = '0, drop_mask = '0;
  logic [CW-1:0] adc_mux_sel, seq_channel;
  logic adc_conv_req, adc_conv_done, seq_valid, scan_busy, scan_done, timeout_err;
  logic [DW-1:0] adc_conv_data, seq_data;
  int total = 0, bad = 0, cyc = 0, trig_s = 0, trig_r = 0, last_req = 0;
  int req_cnt = 0, done_cnt = 0, vcnt = 0, stray_req = 0, stray_ack = 0;
  logic rp = 1'b0, dp = 1'b0, ep = 1'b0;
  logic [CW+DW-1:0] exp_q[$];
  typedef struct {logic [NCH-1:0] mask, mask_run, drop;} vec_t;
  vec_t vt[6];
  neural_scan_sequencer #(.DATA_WIDTH(DW), .CH_ID_WIDTH(CW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
    .sensor_clk(sensor_clk), .sensor_rst_n(sensor_rst_n), .scan_start(scan_start), .scan_stop(scan_stop),
    .continuous(continuous), .ch_enable_mask(ch_enable_mask), .err_clr(err_clr),
    .adc_mux_sel(adc_mux_sel), .adc_conv_req(adc_conv_req), .adc_conv_done(adc_conv_done),
    .adc_conv_data(adc_conv_data), .seq_data(seq_data), .seq_channel(seq_channel), .seq_valid(seq_valid),
    .scan_busy(scan_busy), .scan_done(scan_done), .timeout_err(timeout_err)
  );
  always #5 sensor_clk = ~sensor_clk;
  always @(posedge sensor_clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic pulse_start();
    scan_start = 1'b1;
    @(negedge sensor_clk);
    scan_start = 1'b0;
    trig_s = cyc;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (scan_busy && k < 3000) begin
      @(negedge sensor_clk);
      k++;
    end
    chk("idle_timeout", 32'(scan_busy), 0);
    repeat (3) @(negedge sensor_clk);
  endtask
  task automatic cont_run(input logic [NCH-1:0] m, input int sc, input int passes);
    int n = 0, k = 0, br, bd;
    ch_enable_mask = m;
    continuous = 1'b1;
    drop_mask = '0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < NCH; i++) if (m[i]) exp_q.push_back({CW'(i), DW'(i * 100)});
    @(posedge sensor_clk); #1;
    br = req_cnt;
    bd = done_cnt;
    @(negedge sensor_clk);
    pulse_start();
    while (n < passes && k < 5000) begin
      @(negedge sensor_clk);
      k++;
      if (adc_conv_req && adc_mux_sel == CW'(sc)) n++;
    end
    chk("cont_stop_seen", 32'(n), 32'(passes));
    scan_stop = 1'b1;
    @(negedge sensor_clk);
    scan_stop = 1'b0;
    wait_idle();
    continuous = 1'b0;
    @(posedge sensor_clk); #1;
    chk("cont_reqs", 32'(req_cnt - br), 32'(passes * $countones(m)));
    chk("cont_done", 32'(done_cnt - bd), 32'(passes - 1));
    chk("cont_queue", 32'(exp_q.size()), 0);
    @(negedge sensor_clk);
  endtask
  initial begin
    logic [CW+DW-1:0] e;
    forever begin
      @(negedge sensor_clk);
      if (seq_valid) begin
        vcnt++;
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(seq_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("seq_channel", 32'(seq_channel), 32'(e[CW+DW-1:DW]));
          chk("seq_data", 32'(seq_data), 32'(e[DW-1:0]));
        end
      end
      if (adc_conv_req) begin
        req_cnt++;
        last_req = cyc;
        chk("req_width", 32'(rp), 0);
        chk("req_gap", 32'(cyc - (trig_s > trig_r ? trig_s : trig_r)), SET);
      end
      if (scan_done) begin
        done_cnt++;
        chk("done_width", 32'(dp), 0);
      end
      if (timeout_err && !ep) chk("timeout_latency", 32'(cyc - last_req), TMO);
      rp = adc_conv_req;
      dp = scan_done;
      ep = timeout_err;
    end
  end
  initial begin
    int ch;
    adc_conv_done = 1'b0;
    adc_conv_data = '0;
    forever begin
      @(negedge sensor_clk);
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        adc_conv_done = 1'b1;
        adc_conv_data = 16'h1234;
        @(negedge sensor_clk);
        adc_conv_done = 1'b0;
      end else if (adc_conv_req) begin
        ch = int'(adc_mux_sel);
        if (drop_mask[ch]) begin
          repeat (TMO) @(negedge sensor_clk);
          trig_r = cyc;
        end else begin
          repeat (3) @(negedge sensor_clk);
          adc_conv_done = 1'b1;
          adc_conv_data = DW'(ch * 100);
          @(negedge sensor_clk);
          adc_conv_done = 1'b0;
          trig_r = cyc;
        end
      end
    end
  end
  initial begin
    int br, bd, bv, k;
    vt[0] = '{16'h0025, 16'h0025, 16'h0000};
    vt[1] = '{16'h0006, 16'h0006, 16'h0002};
    vt[2] = '{16'h0000, 16'h0000, 16'h0000};
    vt[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    vt[4] = '{16'h8000, 16'h8000, 16'h8000};
    vt[5] = '{16'h0003, 16'h0004, 16'h0000};
    repeat (3) @(negedge sensor_clk);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_req", 32'(adc_conv_req), 0);
    chk("rst_valid", 32'(seq_valid), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_mux", 32'(adc_mux_sel), 0);
    chk("rst_data", 32'(seq_data), 0);
    chk("rst_chan", 32'(seq_channel), 0);
    sensor_rst_n = 1'b1;
    @(negedge sensor_clk);
    for (int v = 0; v < 6; v++) begin
      drop_mask = vt[v].drop;
      ch_enable_mask = vt[v].mask;
      err_clr = 1'b1;
      @(negedge sensor_clk);
      err_clr = 1'b0;
      chk("err_clr", 32'(timeout_err), 0);
      for (int i = 0; i < NCH; i++)
        if (vt[v].mask[i] && !vt[v].drop[i]) exp_q.push_back({CW'(i), DW'(i * 100)});
      @(posedge sensor_clk); #1;
      br = req_cnt;
      bd = done_cnt;
      @(negedge sensor_clk);
      pulse_start();
      ch_enable_mask = vt[v].mask_run;
      chk("busy_after_start", 32'(scan_busy), 32'(|vt[v].mask));
      wait_idle();
      @(posedge sensor_clk); #1;
      chk("vec_reqs", 32'(req_cnt - br), 32'($countones(vt[v].mask)));
      chk("vec_done", 32'(done_cnt - bd), 32'(|vt[v].mask));
      chk("vec_err", 32'(timeout_err), 32'(|(vt[v].mask & vt[v].drop)));
      chk("vec_queue", 32'(exp_q.size()), 0);
      @(negedge sensor_clk);
    end
    cont_run(16'h8001, 15, 3);
    cont_run(16'h0008, 3, 3);
    ch_enable_mask = 16'h0010;
    @(posedge sensor_clk); #1;
    br = req_cnt;
    bd = done_cnt;
    @(negedge sensor_clk);
    pulse_start();
    scan_stop = 1'b1;
    @(negedge sensor_clk);
    scan_stop = 1'b0;
    chk("settle_stop_busy", 32'(scan_busy), 0);
    repeat (8) @(negedge sensor_clk);
    @(posedge sensor_clk); #1;
    chk("settle_stop_reqs", 32'(req_cnt - br), 0);
    chk("settle_stop_done", 32'(done_cnt - bd), 0);
    @(negedge sensor_clk);
    drop_mask = 16'h0001;
    ch_enable_mask = 16'h0001;
    pulse_start();
    k = 0;
    while (!adc_conv_req && k < 50) begin
      @(negedge sensor_clk);
      k++;
    end
    chk("rst_wait_req_seen", 32'(adc_conv_req), 1);
    repeat (2) @(negedge sensor_clk);
    chk("rst_wait_busy", 32'(scan_busy), 1);
    sensor_rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(scan_busy), 0);
    chk("arst_req", 32'(adc_conv_req), 0);
    chk("arst_valid", 32'(seq_valid), 0);
    chk("arst_done", 32'(scan_done), 0);
    chk("arst_err", 32'(timeout_err), 0);
    chk("arst_data", 32'(seq_data), 0);
    chk("arst_chan", 32'(seq_channel), 0);
    @(negedge sensor_clk);
    sensor_rst_n = 1'b1;
    repeat (80) @(negedge sensor_clk);
    @(posedge sensor_clk); #1;
    bv = vcnt;
    @(negedge sensor_clk);
    stray_req++;
    repeat (10) @(negedge sensor_clk);
    @(posedge sensor_clk); #1;
    chk("stray_done_valid", 32'(vcnt - bv), 0);
    chk("stray_done_busy", 32'(scan_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
